// File: rtl/key_event_fifo.sv
// Turns the keyboard decoder's level outputs into keystroke events (press plus
// typematic auto-repeat) and queues their ASCII codes in a show-ahead FIFO.
module key_event_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 2500000,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic [7:0]                 current_key,
    input  logic [7:0]                 ascii_key,
    input  logic                       rd_en,
    input  logic                       clr_overflow,
    output logic [7:0]                 rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] DELAY_LOAD = CNTW'(REPEAT_DELAY - 1);
    localparam logic [CNTW-1:0] RATE_LOAD  = CNTW'(REPEAT_RATE - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [7:0]      key_q;
    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];

    logic press_ev;
    logic repeat_ev;
    logic push_req;
    logic pop;
    logic push_ok;

    assign press_ev = (current_key != 8'h00) && (current_key != key_q);

    // Release beats counter expiry, and a key change beats a same-cycle repeat.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        repeat_ev = 1'b0;
        if (REPEAT_EN) begin
            if (current_key == 8'h00) begin
                state_d = ST_IDLE;
            end else if (press_ev) begin
                state_d = ST_DELAY;
                cnt_d   = DELAY_LOAD;
            end else if (state_q == ST_DELAY || state_q == ST_REPEAT) begin
                if (cnt_q == '0) begin
                    repeat_ev = 1'b1;
                    state_d   = ST_REPEAT;
                    cnt_d     = RATE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
        end
    end

    assign push_req = (press_ev || repeat_ev) && (ascii_key != 8'h00);
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = rd_en && !empty;
    assign push_ok  = push_req && (!full || pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A dropped event sets the flag even when a clear arrives in the same cycle.
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            key_q      <= 8'h00;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            key_q      <= current_key;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= ascii_key;
        end
    end

    // Forcing zero while empty keeps rd_data at its reset value after clrn.
    assign rd_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: a press-only depth-4 instance and an auto-repeat
// depth-8 instance share stimulus and are checked against a queue-based model.
module tb_key_event_fifo;

    localparam int D = 4;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] current_key = 8'h00;
    logic [7:0] ascii_key = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_overflow = 1'b0;

    logic [7:0] rd_data0, rd_data1;
    logic       empty0, empty1, full0, full1, overflow0, overflow1;
    logic [2:0] count0;
    logic [3:0] count1;

    int total = 0;
    int bad = 0;

    logic [7:0] m_keyq;
    int         m_age;
    logic [7:0] m_q0[$];
    logic [7:0] m_q1[$];
    bit         m_ovf0, m_ovf1;

    always #5 clk = ~clk;

    key_event_fifo #(.DEPTH(4), .REPEAT_DELAY(D), .REPEAT_RATE(R), .REPEAT_EN(1'b0)) u_dut0 (
        .clk(clk), .clrn(clrn), .current_key(current_key), .ascii_key(ascii_key),
        .rd_en(rd_en), .clr_overflow(clr_overflow), .rd_data(rd_data0), .empty(empty0),
        .full(full0), .count(count0), .overflow(overflow0));

    key_event_fifo #(.DEPTH(8), .REPEAT_DELAY(D), .REPEAT_RATE(R), .REPEAT_EN(1'b1)) u_dut1 (
        .clk(clk), .clrn(clrn), .current_key(current_key), .ascii_key(ascii_key),
        .rd_en(rd_en), .clr_overflow(clr_overflow), .rd_data(rd_data1), .empty(empty1),
        .full(full1), .count(count1), .overflow(overflow1));

    task automatic model_reset();
        m_keyq = 8'h00;
        m_age  = 0;
        m_q0.delete();
        m_q1.delete();
        m_ovf0 = 1'b0;
        m_ovf1 = 1'b0;
    endtask

    task automatic fifo_update(input bit which, input bit push, input logic [7:0] data);
        bit pop;
        bit is_full;
        if (which == 1'b0) begin
            pop     = rd_en && (m_q0.size() != 0);
            is_full = (m_q0.size() == 4);
            if (pop) void'(m_q0.pop_front());
            if (push && (!is_full || pop)) m_q0.push_back(data);
            if (push && is_full && !pop) m_ovf0 = 1'b1;
            else if (clr_overflow) m_ovf0 = 1'b0;
        end else begin
            pop     = rd_en && (m_q1.size() != 0);
            is_full = (m_q1.size() == 8);
            if (pop) void'(m_q1.pop_front());
            if (push && (!is_full || pop)) m_q1.push_back(data);
            if (push && is_full && !pop) m_ovf1 = 1'b1;
            else if (clr_overflow) m_ovf1 = 1'b0;
        end
    endtask

    // One clock cycle: events are derived from the key's age since its press.
    task automatic step();
        bit press, rep;
        press = (current_key != 8'h00) && (current_key != m_keyq);
        rep   = 1'b0;
        if (current_key == 8'h00 || press) begin
            m_age = 0;
        end else begin
            m_age++;
            if (m_age >= D && ((m_age - D) % R) == 0) rep = 1'b1;
        end
        @(posedge clk);
        fifo_update(1'b0, press && ascii_key != 8'h00, ascii_key);
        fifo_update(1'b1, (press || rep) && ascii_key != 8'h00, ascii_key);
        m_keyq = current_key;
        #1;
    endtask

    task automatic press_release(input logic [7:0] k, input logic [7:0] a);
        current_key = k;
        ascii_key   = a;
        step();
        current_key = 8'h00;
        ascii_key   = 8'h00;
        step();
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 clrn = 1'b1;
        @(negedge clk);
        total++;
        if (empty0 !== 1'b1 || count0 !== 3'd0 || overflow0 !== 1'b0 || rd_data0 !== 8'h00 || full0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_dut0 empty=%b count=%0d ovf=%b rd=%h full=%b required 1/0/0/00/0",
                     empty0, count0, overflow0, rd_data0, full0);
        end
        total++;
        if (empty1 !== 1'b1 || count1 !== 4'd0 || overflow1 !== 1'b0 || rd_data1 !== 8'h00 || full1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_dut1 empty=%b count=%0d ovf=%b rd=%h full=%b required 1/0/0/00/0",
                     empty1, count1, overflow1, rd_data1, full1);
        end
        $display("test_reset checked");
    endtask

    task automatic test_basic_press();
        current_key = 8'h1C;
        ascii_key   = 8'h61;
        repeat (3) step();
        current_key = 8'h00;
        ascii_key   = 8'h00;
        step();
        total++;
        if (count0 !== 3'd1 || rd_data0 !== 8'h61) begin
            bad++;
            $display("FAIL basic_push count=%0d rd=%h required 1/61", count0, rd_data0);
        end
        total++;
        if (count1 !== 4'(m_q1.size()) || rd_data1 !== 8'h61) begin
            bad++;
            $display("FAIL basic_push_rep count=%0d rd=%h required %0d/61", count1, rd_data1, m_q1.size());
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        total++;
        if (empty0 !== 1'b1 || count0 !== 3'd0 || empty1 !== 1'b1) begin
            bad++;
            $display("FAIL basic_pop empty0=%b count0=%0d empty1=%b required 1/0/1", empty0, count0, empty1);
        end
        $display("test_basic_press checked");
    endtask

    task automatic test_key_change();
        current_key = 8'h1C; ascii_key = 8'h61; repeat (2) step();
        current_key = 8'h32; ascii_key = 8'h62; repeat (2) step();
        current_key = 8'h12; ascii_key = 8'h00; repeat (2) step();
        current_key = 8'h00; step();
        total++;
        if (count0 !== 3'd2 || rd_data0 !== 8'h61 || count1 !== 4'd2) begin
            bad++;
            $display("FAIL key_change count0=%0d rd0=%h count1=%0d required 2/61/2", count0, rd_data0, count1);
        end
        rd_en = 1'b1;
        step();
        total++;
        if (rd_data0 !== 8'h62 || rd_data1 !== 8'h62 || count0 !== 3'd1) begin
            bad++;
            $display("FAIL key_change_second rd0=%h rd1=%h count0=%0d required 62/62/1", rd_data0, rd_data1, count0);
        end
        step();
        rd_en = 1'b0;
        total++;
        if (empty0 !== 1'b1 || empty1 !== 1'b1) begin
            bad++;
            $display("FAIL key_change_drain empty0=%b empty1=%b required 1/1", empty0, empty1);
        end
        $display("test_key_change checked");
    endtask

    task automatic test_auto_repeat();
        current_key = 8'h1C;
        ascii_key   = 8'h61;
        for (int c = 0; c < 12; c++) begin
            step();
            total++;
            if (count1 !== 4'(m_q1.size())) begin
                bad++;
                $display("FAIL repeat_cycle%0d count=%0d required %0d", c, count1, m_q1.size());
            end
        end
        current_key = 8'h00;
        ascii_key   = 8'h00;
        repeat (6) step();
        total++;
        if (count1 !== 4'd5 || count0 !== 3'd1 || overflow1 !== 1'b0) begin
            bad++;
            $display("FAIL repeat_total count1=%0d count0=%0d ovf1=%b required 5/1/0", count1, count0, overflow1);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rd_data1 !== 8'h61) begin
                bad++;
                $display("FAIL repeat_pop%0d rd=%h required 61", i, rd_data1);
            end
            step();
        end
        rd_en = 1'b0;
        total++;
        if (empty1 !== 1'b1 || empty0 !== 1'b1) begin
            bad++;
            $display("FAIL repeat_drain empty1=%b empty0=%b required 1/1", empty1, empty0);
        end
        $display("test_auto_repeat checked");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) press_release(8'(8'h10 + i), 8'(8'h41 + i));
        total++;
        if (full0 !== 1'b1 || count0 !== 3'd4 || overflow0 !== 1'b1) begin
            bad++;
            $display("FAIL overflow_flags full=%b count=%0d ovf=%b required 1/4/1", full0, count0, overflow0);
        end
        total++;
        if (count1 !== 4'd5 || overflow1 !== 1'b0) begin
            bad++;
            $display("FAIL overflow_deep count=%0d ovf=%b required 5/0", count1, overflow1);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data0 !== 8'(8'h41 + i) || rd_data1 !== 8'(8'h41 + i)) begin
                bad++;
                $display("FAIL overflow_pop%0d rd0=%h rd1=%h required %h", i, rd_data0, rd_data1, 8'(8'h41 + i));
            end
            step();
        end
        total++;
        if (empty0 !== 1'b1 || rd_data1 !== 8'h45 || overflow0 !== 1'b1) begin
            bad++;
            $display("FAIL overflow_dropped empty0=%b rd1=%h ovf0=%b required 1/45/1", empty0, rd_data1, overflow0);
        end
        step();
        rd_en        = 1'b0;
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        total++;
        if (overflow0 !== 1'b0 || empty1 !== 1'b1) begin
            bad++;
            $display("FAIL overflow_clear ovf0=%b empty1=%b required 0/1", overflow0, empty1);
        end
        $display("test_overflow checked");
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp0 [4];
        exp0[0] = 8'h42; exp0[1] = 8'h43; exp0[2] = 8'h44; exp0[3] = 8'h46;
        for (int i = 0; i < 4; i++) press_release(8'(8'h10 + i), 8'(8'h41 + i));
        current_key = 8'h15; ascii_key = 8'h46; rd_en = 1'b1;
        step();
        rd_en = 1'b0; current_key = 8'h00; ascii_key = 8'h00;
        total++;
        if (count0 !== 3'd4 || overflow0 !== 1'b0 || rd_data0 !== 8'h42 || count1 !== 4'd4) begin
            bad++;
            $display("FAIL full_push_pop count0=%0d ovf0=%b rd0=%h count1=%0d required 4/0/42/4",
                     count0, overflow0, rd_data0, count1);
        end
        step();
        current_key = 8'h16; ascii_key = 8'h47; clr_overflow = 1'b1;
        step();
        current_key = 8'h00; ascii_key = 8'h00; clr_overflow = 1'b0;
        total++;
        if (overflow0 !== 1'b1 || overflow1 !== 1'b0 || count1 !== 4'd5) begin
            bad++;
            $display("FAIL set_beats_clear ovf0=%b ovf1=%b count1=%0d required 1/0/5", overflow0, overflow1, count1);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_data0 !== exp0[i] || rd_data1 !== exp0[i]) begin
                bad++;
                $display("FAIL full_order%0d rd0=%h rd1=%h required %h", i, rd_data0, rd_data1, exp0[i]);
            end
            step();
        end
        step();
        rd_en = 1'b0;
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        total++;
        if (empty0 !== 1'b1 || empty1 !== 1'b1 || overflow0 !== 1'b0) begin
            bad++;
            $display("FAIL full_drain empty0=%b empty1=%b ovf0=%b required 1/1/0", empty0, empty1, overflow0);
        end
        $display("test_full_push_pop checked");
    endtask

    task automatic test_random();
        logic [7:0] keys [5];
        logic [7:0] ascs [5];
        int sel = 0;
        int errs = 0;
        keys[0] = 8'h00; keys[1] = 8'h1C; keys[2] = 8'h32; keys[3] = 8'h12; keys[4] = 8'h21;
        ascs[0] = 8'h00; ascs[1] = 8'h61; ascs[2] = 8'h62; ascs[3] = 8'h00; ascs[4] = 8'h63;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) sel = int'($urandom_range(0, 4));
            current_key  = keys[sel];
            ascii_key    = ascs[sel];
            rd_en        = ($urandom_range(0, 3) == 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            step();
            total++;
            if (count0 !== 3'(m_q0.size()) || empty0 !== (m_q0.size() == 0) || full0 !== (m_q0.size() == 4)
                || overflow0 !== m_ovf0 || (m_q0.size() != 0 && rd_data0 !== m_q0[0])) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL random_dut0 cyc=%0d count=%0d ovf=%b rd=%h required %0d/%b/%h",
                             c, count0, overflow0, rd_data0, m_q0.size(), m_ovf0, (m_q0.size() != 0) ? m_q0[0] : 8'h00);
            end
            total++;
            if (count1 !== 4'(m_q1.size()) || empty1 !== (m_q1.size() == 0) || full1 !== (m_q1.size() == 8)
                || overflow1 !== m_ovf1 || (m_q1.size() != 0 && rd_data1 !== m_q1[0])) begin
                bad++; errs++;
                if (errs < 10)
                    $display("FAIL random_dut1 cyc=%0d count=%0d ovf=%b rd=%h required %0d/%b/%h",
                             c, count1, overflow1, rd_data1, m_q1.size(), m_ovf1, (m_q1.size() != 0) ? m_q1[0] : 8'h00);
            end
        end
        current_key = 8'h00; ascii_key = 8'h00; rd_en = 1'b0; clr_overflow = 1'b0;
        $display("test_random checked 600 cycles");
    endtask

    task automatic test_async_reset();
        press_release(8'h1C, 8'h61);
        press_release(8'h32, 8'h62);
        current_key = 8'h21; ascii_key = 8'h63;
        step();
        #2 clrn = 1'b0;
        #1;
        model_reset();
        total++;
        if (empty0 !== 1'b1 || count0 !== 3'd0 || overflow0 !== 1'b0 || rd_data0 !== 8'h00 || full0 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_dut0 empty=%b count=%0d ovf=%b rd=%h required 1/0/0/00", empty0, count0, overflow0, rd_data0);
        end
        total++;
        if (empty1 !== 1'b1 || count1 !== 4'd0 || overflow1 !== 1'b0 || rd_data1 !== 8'h00 || full1 !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_dut1 empty=%b count=%0d ovf=%b rd=%h required 1/0/0/00", empty1, count1, overflow1, rd_data1);
        end
        current_key = 8'h00; ascii_key = 8'h00;
        @(negedge clk);
        clrn = 1'b1;
        step();
        press_release(8'h1C, 8'h61);
        total++;
        if (count0 !== 3'd1 || rd_data0 !== 8'h61 || count1 !== 4'd1) begin
            bad++;
            $display("FAIL after_reset count0=%0d rd0=%h count1=%0d required 1/61/1", count0, rd_data0, count1);
        end
        $display("test_async_reset checked");
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_key_change();
        test_auto_repeat();
        test_overflow();
        test_full_push_pop();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Sits directly downstream of the keyboard decoder.
- Converts its level outputs (current_key scancode, ascii_key) into discrete keystroke events and queues their ASCII codes in a FIFO for the CPU/terminal to read.
- Generates typematic auto-repeat for a held key.
- Records FIFO overflow in a sticky flag.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, at least 2.
- REPEAT_DELAY, 25000000, cycles a key must be held before the first repeat; at least 1.
- REPEAT_RATE, 2500000, cycles between successive repeats; at least 1.
- REPEAT_EN, 1, 1 enables auto-repeat; 0 gives press events only.

Ports:
- clk  in  1  system clock; all logic on posedge.
- clrn  in  1  asynchronous active-low reset.
- current_key  in  8  scancode of the held key; 0 means no key is held.
- ascii_key  in  8  ASCII of current_key; 0 means no printable mapping (modifiers).
- rd_en  in  1  pop request from the consumer.
- clr_overflow  in  1  clears the overflow flag.
- rd_data  out  8  head-of-FIFO ASCII (show-ahead).
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds DEPTH entries.
- count  out  log2(DEPTH)+1  number of entries held.
- overflow  out  1  sticky: an event was dropped.

Behaviour:
- Reset (clrn=0, asynchronous):
  - Pointers and count go to 0; empty=1, full=0, overflow=0.
  - rd_data=0; key_q=0; state IDLE; counter=0.
  - Reset asserted mid-operation discards all queued data immediately.
- key_q: registered copy of current_key, updated every cycle.
- Press event: current_key!=0 and current_key!=key_q, evaluated combinationally in cycle N. It covers release-to-press and direct key-to-key change.
- Push request: press event or repeat event, and ascii_key!=0. Modifier-only keys never push but still drive the state machine.
- Push writes ascii_key at the posedge ending cycle N; empty/count update after that edge (1-cycle latency).
- Repeat FSM, active only when REPEAT_EN=1 (with REPEAT_EN=0 it stays IDLE):
  - IDLE: on press event, load counter=REPEAT_DELAY-1 and go to DELAY.
  - DELAY: counter decrements each cycle.
    - Counter at 0 with key still held: repeat event; load REPEAT_RATE-1 and go to REPEAT.
  - REPEAT: counter decrements each cycle.
    - Counter at 0: repeat event; reload REPEAT_RATE-1.
  - Any state, current_key==0: go to IDLE, no event. This has priority over counter expiry.
  - Any state, press event (key change): push the new key, reload REPEAT_DELAY-1, go to DELAY. This has priority over a same-cycle repeat, so only one push occurs.
  - Repeat events push the ascii_key present in that cycle.
- FIFO read:
  - rd_data always shows the head entry; it is don't-care while empty.
  - rd_en=1 with empty=0 pops at the posedge; rd_data shows the next entry after that edge.
  - rd_en while empty is ignored; no underflow state.
- Simultaneous push and pop:
  - Both occur and count is unchanged, including when full.
  - When empty, the pop is ignored and the push succeeds.
- Push while full without pop: the entry is dropped, FIFO contents are unchanged, and overflow is set.
- overflow is cleared by clr_overflow. If a set and clr_overflow occur in the same cycle, set wins.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- full = (count==DEPTH); empty = (count==0).

Test Plan:
- Reset then release: empty=1, count=0, overflow=0, rd_data=0.
- Basic press/pop (REPEAT_EN=0): current_key 0→0x1C, ascii_key=0x61 for 3 cycles, then 0.
  - Exactly one push: count=1, rd_data=0x61.
  - rd_en one cycle → empty=1, count=0.
- Key change without release: 0x1C/0x61 then directly 0x32/0x62, then 0 → two entries, 0x61 then 0x62. A shift-only press (current_key=0x12, ascii_key=0) pushes nothing.
- Auto-repeat (REPEAT_DELAY=4, REPEAT_RATE=2): hold 0x61 for 12 cycles.
  - Pushes at the press cycle, press+4, +6, +8, +10.
  - count=5; release → no further pushes.
- Overflow (DEPTH=4): 5 distinct presses without reads.
  - full=1, count=4, overflow=1; the 5th key is dropped.
  - Pops return the first four in order.
  - clr_overflow → overflow=0.
- Full with simultaneous push+pop: count stays 4, oldest entry leaves, new entry at tail, overflow=0.
- clrn pulsed low mid-stream: all outputs return to their reset values immediately, without a clock edge.
